alu_result_stage: RTL and testbench

- Registered output stage directly downstream of the combinational logic units (and/or/xor/not).
- Captures each unit's WIDTH-bit result plus its N/Z/C/V flags and an op tag.
- Delivers them through a valid/ready skid buffer, so the datapath can be back-pressured without combinational ready paths.
- Maintains an architectural status register holding the flags of the last retired result.

---
 rtl/alu_pkg.sv | 48 ++++
 rtl/alu_result_stage_skid_buffer.sv | 120 ++++++++++++
 rtl/alu_result_stage.sv | 123 ++++++++++++
 tb/tb_alu_result_stage.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : Shared definitions for the ALU result stage: flag bit
//               positions, the packed flag type, default widths, the skid
//               buffer state encoding and a flag-packing helper.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    // Bit positions of each flag inside a packed {N,Z,C,V} nibble.
    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    // Default widths of the datapath result and the opcode tag.
    localparam int WIDTH_DEFAULT = 8;
    localparam int OP_W_DEFAULT  = 4;

    typedef logic [3:0] alu_flags_t;

    // Two-entry skid buffer occupancy.
    typedef enum logic [1:0] {
        SB_EMPTY = 2'd0,
        SB_ONE   = 2'd1,
        SB_TWO   = 2'd2
    } skid_state_t;

    // Place the individual flags at their fixed bit positions. No flag is
    // recomputed here; this is purely a positional packing.
    function automatic alu_flags_t pack_flags(
        input logic n,
        input logic z,
        input logic c,
        input logic v
    );
        alu_flags_t f;
        f         = '0;
        f[FLAG_N] = n;
        f[FLAG_Z] = z;
        f[FLAG_C] = c;
        f[FLAG_V] = v;
        return f;
    endfunction

endpackage : alu_pkg
`default_nettype wire

// File: rtl/alu_result_stage_skid_buffer.sv
`default_nettype none
// ============================================================================
// Module      : skid_buffer
// Description : Generic two-entry valid/ready buffer. The main entry drives
//               the output; the skid entry absorbs one extra item so that the
//               upstream ready can be a pure register output.
// Ports       : clk, rst_n            - clock, async active-low reset
//               i_valid/o_ready/i_data - upstream handshake and payload
//               o_valid/i_ready/o_data - downstream handshake and payload
// Parameters  : DATA_W - payload width
// Revision    : 1.0 - initial release
// ============================================================================
module skid_buffer
    import alu_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [DATA_W-1:0] o_data
);

    skid_state_t       r_state;
    skid_state_t       w_state_nxt;
    logic [DATA_W-1:0] r_main;
    logic [DATA_W-1:0] r_skid;
    logic              r_ready;

    logic              w_accept;
    logic              w_retire;
    logic              w_load_main;
    logic              w_load_skid;
    logic              w_shift;

    assign o_valid  = (r_state != SB_EMPTY);
    assign o_ready  = r_ready;
    assign o_data   = r_main;

    // r_ready is low only in SB_TWO, so nothing is ever accepted when both
    // entries are occupied.
    assign w_accept = i_valid & r_ready;
    assign w_retire = o_valid & i_ready;

    // ------------------------------------------------------------------
    // Next-state and datapath control
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_load_main = 1'b0;
        w_load_skid = 1'b0;
        w_shift     = 1'b0;
        case (r_state)
            SB_EMPTY: begin
                if (w_accept) begin
                    w_state_nxt = SB_ONE;
                    w_load_main = 1'b1;
                end
            end
            SB_ONE: begin
                if (w_accept && !w_retire) begin
                    w_state_nxt = SB_TWO;
                    w_load_skid = 1'b1;
                end else if (w_accept && w_retire) begin
                    // Head leaves and the new item takes its place at once.
                    w_load_main = 1'b1;
                end else if (w_retire) begin
                    w_state_nxt = SB_EMPTY;
                end
            end
            SB_TWO: begin
                if (w_retire) begin
                    w_state_nxt = SB_ONE;
                    w_shift     = 1'b1;
                end
            end
            default: begin
                w_state_nxt = SB_EMPTY;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State and registered ready
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= SB_EMPTY;
            r_ready <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_ready <= (w_state_nxt != SB_TWO);
        end
    end

    // ------------------------------------------------------------------
    // Entry storage
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_main <= '0;
            r_skid <= '0;
        end else begin
            if (w_load_main) begin
                r_main <= i_data;
            end else if (w_shift) begin
                r_main <= r_skid;
            end
            if (w_load_skid) begin
                r_skid <= i_data;
            end
        end
    end

endmodule : skid_buffer
`default_nettype wire

// File: rtl/alu_result_stage.sv
`default_nettype none
// ============================================================================
// Module      : alu_result_stage
// Description : Registered output stage behind the logic units. Captures the
//               result, {N,Z,C,V} flags and op tag, delivers them through a
//               two-entry skid buffer and keeps a status register holding
//               the flags of the last retired result.
// Ports       : clk, rst_n                 - clock, async active-low reset
//               in_valid/in_ready          - upstream handshake
//               in_result, in_op           - result and opcode tag
//               in_negative/zero/cout/overflow - upstream flags
//               out_valid/out_ready        - downstream handshake
//               out_result/out_flags/out_op - head-of-buffer entry
//               status_flags               - flags of last retired result
//               sticky_clear/sticky_flags  - OR-accumulated flags
//                                            (ALU_STICKY_FLAGS_EN only)
// Options     : ALU_STICKY_FLAGS_EN - adds the sticky flag register and ports
// Parameters  : WIDTH - result width, OP_W - opcode tag width
// Revision    : 1.0 - initial release
// ============================================================================
module alu_result_stage
    import alu_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT,
    parameter int OP_W  = OP_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_result,
    input  logic             in_negative,
    input  logic             in_zero,
    input  logic             in_cout,
    input  logic             in_overflow,
    input  logic [OP_W-1:0]  in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic [3:0]       out_flags,
    output logic [OP_W-1:0]  out_op,
`ifdef ALU_STICKY_FLAGS_EN
    input  logic             sticky_clear,
    output logic [3:0]       sticky_flags,
`endif
    output logic [3:0]       status_flags
);

    localparam int c_payload_w = OP_W + 4 + WIDTH;

    logic [c_payload_w-1:0] w_payload_in;
    logic [c_payload_w-1:0] w_payload_out;
    alu_flags_t             w_flags_in;
    logic                   w_retire;
    alu_flags_t             r_status;

    // Payload layout: {op, flags, result}.
    assign w_flags_in   = pack_flags(in_negative, in_zero, in_cout, in_overflow);
    assign w_payload_in = {in_op, w_flags_in, in_result};

    skid_buffer #(
        .DATA_W (c_payload_w)
    ) u_skid (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_valid (in_valid),
        .o_ready (in_ready),
        .i_data  (w_payload_in),
        .o_valid (out_valid),
        .i_ready (out_ready),
        .o_data  (w_payload_out)
    );

    assign out_result = w_payload_out[WIDTH-1:0];
    assign out_flags  = w_payload_out[WIDTH+3:WIDTH];
    assign out_op     = w_payload_out[c_payload_w-1:WIDTH+4];

    assign w_retire   = out_valid & out_ready;

    // ------------------------------------------------------------------
    // Architectural status: flags of the most recently retired result
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_status <= '0;
        end else if (w_retire) begin
            r_status <= out_flags;
        end
    end

    assign status_flags = r_status;

`ifdef ALU_STICKY_FLAGS_EN
    // ------------------------------------------------------------------
    // Sticky flags: a clear is applied first, then the retiring flags are
    // OR-ed in, so a clear coinciding with a retire keeps that retire.
    // ------------------------------------------------------------------
    alu_flags_t r_sticky;
    alu_flags_t w_sticky_nxt;

    always_comb begin
        w_sticky_nxt = r_sticky;
        if (sticky_clear) begin
            w_sticky_nxt = '0;
        end
        if (w_retire) begin
            w_sticky_nxt = w_sticky_nxt | out_flags;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sticky <= '0;
        end else begin
            r_sticky <= w_sticky_nxt;
        end
    end

    assign sticky_flags = r_sticky;
`endif

endmodule : alu_result_stage
`default_nettype wire

// File: tb/tb_alu_result_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_result_stage
// Description : Self-checking bench for alu_result_stage. A queue-based
//               reference model tracks the buffered entries, the status
//               register and (with ALU_STICKY_FLAGS_EN) the sticky flags.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_result_stage;
    import alu_pkg::*;

    localparam int WIDTH = 8;
    localparam int OP_W  = 4;

    typedef struct packed {
        logic [OP_W-1:0]  op;
        logic [3:0]       flags;
        logic [WIDTH-1:0] res;
    } ent_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] in_result = '0;
    logic             in_negative = 1'b0;
    logic             in_zero = 1'b0;
    logic             in_cout = 1'b0;
    logic             in_overflow = 1'b0;
    logic [OP_W-1:0]  in_op = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] out_result;
    logic [3:0]       out_flags;
    logic [OP_W-1:0]  out_op;
    logic [3:0]       status_flags;
    logic             sticky_clear = 1'b0;
    logic [3:0]       sticky_flags;

    always #5 clk = ~clk;

    alu_result_stage #(
        .WIDTH (WIDTH),
        .OP_W  (OP_W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_result    (in_result),
        .in_negative  (in_negative),
        .in_zero      (in_zero),
        .in_cout      (in_cout),
        .in_overflow  (in_overflow),
        .in_op        (in_op),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_result   (out_result),
        .out_flags    (out_flags),
        .out_op       (out_op),
`ifdef ALU_STICKY_FLAGS_EN
        .sticky_clear (sticky_clear),
        .sticky_flags (sticky_flags),
`endif
        .status_flags (status_flags)
    );

`ifndef ALU_STICKY_FLAGS_EN
    assign sticky_flags = 4'h0;
`endif

    // Reference model
    ent_t             q[$];
    logic [WIDTH-1:0] obs_retired[$];
    logic [3:0]       m_status = 4'h0;
    logic [3:0]       m_sticky = 4'h0;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic cmp_outputs();
        check("in_ready", 32'(in_ready), 32'(q.size() < 2));
        check("out_valid", 32'(out_valid), 32'(q.size() != 0));
        if (q.size() != 0) begin
            check("out_result", 32'(out_result), 32'(q[0].res));
            check("out_flags", 32'(out_flags), 32'(q[0].flags));
            check("out_op", 32'(out_op), 32'(q[0].op));
        end
        check("status_flags", 32'(status_flags), 32'(m_status));
`ifdef ALU_STICKY_FLAGS_EN
        check("sticky_flags", 32'(sticky_flags), 32'(m_sticky));
`endif
    endtask

    // One clock cycle: compare outputs at the falling edge, drive inputs,
    // then advance the model at the rising edge.
    task automatic step(input logic v, input ent_t e, input logic ordy,
                        input logic clr, output logic acc);
        logic ret;
        ent_t h;
        @(negedge clk);
        cmp_outputs();
        in_valid     = v;
        in_result    = e.res;
        in_negative  = e.flags[FLAG_N];
        in_zero      = e.flags[FLAG_Z];
        in_cout      = e.flags[FLAG_C];
        in_overflow  = e.flags[FLAG_V];
        in_op        = e.op;
        out_ready    = ordy;
        sticky_clear = clr;
        acc = v && (q.size() < 2);
        ret = ordy && (q.size() != 0);
        if (ret) obs_retired.push_back(out_result);
        @(posedge clk);
        if (clr) m_sticky = 4'h0;
        if (ret) begin
            h        = q.pop_front();
            m_status = h.flags;
            m_sticky = m_sticky | h.flags;
        end
        if (acc) q.push_back(e);
    endtask

    function automatic ent_t mk(input logic [7:0] res, input logic [3:0] fl, input logic [3:0] op);
        ent_t e;
        e.res   = res;
        e.flags = fl;
        e.op    = op;
        return e;
    endfunction

    initial begin
        logic acc;
        ent_t cur;
        logic have;
        logic v;
        logic [31:0] r;
        int base;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'h0);
        check("rst_in_ready", 32'(in_ready), 32'h1);
        check("rst_out_result", 32'(out_result), 32'h0);
        check("rst_out_flags", 32'(out_flags), 32'h0);
        check("rst_out_op", 32'(out_op), 32'h0);
        check("rst_status", 32'(status_flags), 32'h0);
        check("rst_sticky", 32'(sticky_flags), 32'h0);
        rst_n = 1'b1;

        // Single zero result, one-cycle latency, status after retire
        step(1'b1, mk(8'h00, 4'b0100, 4'h3), 1'b1, 1'b0, acc);
        #1;
        check("t1_valid", 32'(out_valid), 32'h1);
        check("t1_result", 32'(out_result), 32'h00);
        check("t1_flags", 32'(out_flags), 32'h4);
        step(1'b0, mk(8'h00, 4'h0, 4'h0), 1'b1, 1'b0, acc);
        #1;
        check("t1_status", 32'(status_flags), 32'h4);

        // Back-to-back stream 0x01..0x10
        base = obs_retired.size();
        for (int i = 1; i <= 16; i++) begin
            step(1'b1, mk(8'(i), 4'(i), 4'(i)), 1'b1, 1'b0, acc);
            #1;
            check("stream_rdy", 32'(in_ready), 32'h1);
            check("stream_data", 32'(out_result), 32'(i));
        end
        step(1'b0, mk(8'h00, 4'h0, 4'h0), 1'b1, 1'b0, acc);
        check("stream_count", 32'(obs_retired.size() - base), 32'd16);
        for (int i = 0; i < 16 && base + i < obs_retired.size(); i++)
            check("stream_order", 32'(obs_retired[base+i]), 32'(i + 1));

        // Back-pressure: fill both entries, third push blocked
        base = obs_retired.size();
        step(1'b1, mk(8'hA5, 4'b1000, 4'h1), 1'b0, 1'b0, acc);
        step(1'b1, mk(8'h5A, 4'b0000, 4'h2), 1'b0, 1'b0, acc);
        #1;
        check("bp_rdy_low", 32'(in_ready), 32'h0);
        step(1'b1, mk(8'hFF, 4'b1000, 4'h3), 1'b0, 1'b0, acc);
        #1;
        check("bp_hold", 32'(out_result), 32'hA5);
        check("bp_rdy_still_low", 32'(in_ready), 32'h0);
        step(1'b1, mk(8'hFF, 4'b1000, 4'h3), 1'b1, 1'b0, acc);
        step(1'b1, mk(8'hFF, 4'b1000, 4'h3), 1'b1, 1'b0, acc);
        step(1'b0, mk(8'h00, 4'h0, 4'h0), 1'b1, 1'b0, acc);
        step(1'b0, mk(8'h00, 4'h0, 4'h0), 1'b1, 1'b0, acc);
        check("bp_count", 32'(obs_retired.size() - base), 32'd3);
        if (obs_retired.size() - base == 3) begin
            check("bp_order0", 32'(obs_retired[base]), 32'hA5);
            check("bp_order1", 32'(obs_retired[base+1]), 32'h5A);
            check("bp_order2", 32'(obs_retired[base+2]), 32'hFF);
        end

        // Asynchronous reset with both entries full
        step(1'b1, mk(8'h11, 4'b0001, 4'h1), 1'b0, 1'b0, acc);
        step(1'b1, mk(8'h22, 4'b0010, 4'h2), 1'b0, 1'b0, acc);
        #3;
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        check("arst_valid", 32'(out_valid), 32'h0);
        check("arst_rdy", 32'(in_ready), 32'h1);
        check("arst_result", 32'(out_result), 32'h0);
        check("arst_status", 32'(status_flags), 32'h0);
        q.delete();
        m_status = 4'h0;
        m_sticky = 4'h0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) step(1'b0, mk(8'h00, 4'h0, 4'h0), 1'b1, 1'b0, acc);
        #1;
        check("arst_no_stale", 32'(out_valid), 32'h0);

`ifdef ALU_STICKY_FLAGS_EN
        // Sticky accumulation and clear-with-retire
        step(1'b0, mk(8'h00, 4'h0, 4'h0), 1'b1, 1'b1, acc);
        step(1'b1, mk(8'h80, 4'b1000, 4'h1), 1'b1, 1'b0, acc);
        step(1'b1, mk(8'h00, 4'b0100, 4'h2), 1'b1, 1'b0, acc);
        step(1'b0, mk(8'h00, 4'h0, 4'h0), 1'b1, 1'b0, acc);
        #1;
        check("sticky_acc", 32'(sticky_flags), 32'hC);
        step(1'b1, mk(8'h01, 4'b0010, 4'h3), 1'b1, 1'b0, acc);
        step(1'b0, mk(8'h00, 4'h0, 4'h0), 1'b1, 1'b1, acc);
        #1;
        check("sticky_clr_retire", 32'(sticky_flags), 32'h2);
`endif

        // Randomized traffic against the queue model
        have = 1'b0;
        cur  = '0;
        for (int c = 0; c < 10000; c++) begin
            if (!have) begin
                r    = $urandom;
                cur  = r[15:0];
                v    = ($urandom_range(0, 3) != 0);
                have = v;
            end else begin
                v = 1'b1;
            end
            step(v, cur,
                 (c < 5000) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 31) == 0), acc);
            if (acc) have = 1'b0;
        end
        repeat (3) step(1'b0, mk(8'h00, 4'h0, 4'h0), 1'b1, 1'b0, acc);
        #1;
        check("final_empty", 32'(out_valid), 32'h0);
        check("final_status", 32'(status_flags), 32'(m_status));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_alu_result_stage
`default_nettype wire
